// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer states and instruction field offsets
package alu_pkg;
  typedef enum logic [2:0] {ADD, SUBTRACT, AND_OP, OR_OP, XOR_OP, NOT_OP, LOAD_OP} instruction_code;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  // Bit offsets above the immediate field, which occupies the low DATA_WIDTH bits
  localparam int CIN_OFS    = 0;
  localparam int IMMSEL_OFS = 1;
  localparam int RS2_OFS    = 2;
  localparam int RS1_OFS    = 4;
  localparam int RD_OFS     = 6;
  localparam int OP_OFS     = 8;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction/result handshake plus register-file debug read
interface alu_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int INSTR_WIDTH  = OPCODE_WIDTH + 8 + DATA_WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_carry;
  logic [1:0]             dbg_addr;
  logic [DATA_WIDTH-1:0]  dbg_data;
  modport master (output in_valid, in_instr, out_ready, dbg_addr,
                  input  in_ready, out_valid, out_data, out_carry, dbg_data);
  modport slave  (input  in_valid, in_instr, out_ready, dbg_addr,
                  output in_ready, out_valid, out_data, out_carry, dbg_data);
endinterface

// File: rtl/alu_sequencer_alu.sv
// alu: combinational datapath; unknown opcodes behave as LOAD_OP
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]   i_1,
  input  logic [DATA_WIDTH-1:0]   i_2,
  input  logic                    i_carry_in,
  input  logic [OPCODE_WIDTH-1:0] i_op_code,
  output logic [DATA_WIDTH-1:0]   o_main,
  output logic                    o_carry_out
);
  instruction_code       w_op;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_cin;
  logic                  w_no_carry;
  always_comb begin
    w_op       = instruction_code'($bits(instruction_code)'(i_op_code));
    w_cin      = DATA_WIDTH'(i_carry_in);
    w_sum      = {1'b0, i_1} + {1'b0, i_2} + {1'b0, w_cin};
    w_no_carry = w_op == SUBTRACT || w_op == AND_OP || w_op == OR_OP || w_op == XOR_OP || w_op == NOT_OP;
    o_main = w_op == ADD      ? w_sum[DATA_WIDTH-1:0] :
             w_op == SUBTRACT ? i_1 - i_2 + w_cin :
             w_op == AND_OP   ? i_1 & i_2 :
             w_op == OR_OP    ? i_1 | i_2 :
             w_op == XOR_OP   ? i_1 ^ i_2 :
             w_op == NOT_OP   ? ~i_1 : i_2;
    o_carry_out = w_op == ADD ? w_sum[DATA_WIDTH] : w_no_carry ? 1'b0 : i_carry_in;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state instruction sequencer around a 4-entry register file and alu
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int INSTR_WIDTH  = OPCODE_WIDTH + 8 + DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);
  state_t                  r_state, w_next;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [DATA_WIDTH-1:0]   r_regs [4];
  logic                    r_carry;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_carry;
  logic [OPCODE_WIDTH-1:0] w_op;
  logic [1:0]              w_rd, w_rs1, w_rs2;
  logic [DATA_WIDTH-1:0]   w_imm, w_a, w_b, w_main;
  logic                    w_cin, w_cout;
  assign w_op  = r_instr[DATA_WIDTH+OP_OFS +: OPCODE_WIDTH];
  assign w_rd  = r_instr[DATA_WIDTH+RD_OFS +: 2];
  assign w_rs1 = r_instr[DATA_WIDTH+RS1_OFS +: 2];
  assign w_rs2 = r_instr[DATA_WIDTH+RS2_OFS +: 2];
  assign w_imm = r_instr[DATA_WIDTH-1:0];
  assign w_a   = r_regs[w_rs1];
  assign w_b   = r_instr[DATA_WIDTH+IMMSEL_OFS] ? w_imm : r_regs[w_rs2];
  assign w_cin = r_instr[DATA_WIDTH+CIN_OFS] & r_carry;
  alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH)) u_alu (
    .i_1(w_a), .i_2(w_b), .i_carry_in(w_cin), .i_op_code(w_op),
    .o_main(w_main), .o_carry_out(w_cout)
  );
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (bus.in_valid ? EXEC : IDLE) :
             r_state == EXEC ? RESP :
             (bus.out_ready ? IDLE : RESP);
  end
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == RESP;
  assign bus.out_data  = r_out_data;
  assign bus.out_carry = r_out_carry;
  assign bus.dbg_data  = r_regs[bus.dbg_addr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_regs      <= '{default: '0};
      r_carry     <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) r_instr <= bus.in_instr;
      if (r_state == EXEC) begin
        r_regs[w_rd] <= w_main;
        r_carry      <= w_cout;
        r_out_data   <= w_main;
        r_out_carry  <= w_cout;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random instructions checked against an arithmetic reference model
module tb_alu_sequencer;
  import alu_pkg::*;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  int m_reg [4];
  int m_carry;
  always #5 clk = ~clk;
  alu_sequencer_if #(.DATA_WIDTH(W)) bus ();
  alu_sequencer #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  function automatic void model_exec(input int op, input int rd, input int rs1, input int rs2,
                                     input int imm_sel, input int cin_sel, input int imm,
                                     output int res, output int c);
    int a, b, ci, s;
    a  = m_reg[rs1];
    b  = imm_sel != 0 ? imm : m_reg[rs2];
    ci = cin_sel != 0 ? m_carry : 0;
    c  = 0;
    case (op)
      0: begin s = a + b + ci; res = s % (MASK + 1); c = s / (MASK + 1); end
      1: res = (a - b + ci + MASK + 1) % (MASK + 1);
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = MASK - a;
      default: begin res = b; c = ci; end
    endcase
    m_reg[rd] = res;
    m_carry   = c;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_carry = 0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_carry"}, 32'(bus.out_carry), 0);
    check({tag, "_out_data"}, 32'(bus.out_data), 0);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1 check({tag, "_dbg"}, 32'(bus.dbg_data), 0);
    end
  endtask
  task automatic offer(input int op, input int rd, input int rs1, input int rs2,
                       input int imm_sel, input int cin_sel, input int imm);
    int w;
    bus.in_instr = {3'(op), 2'(rd), 2'(rs1), 2'(rs2), 1'(imm_sel), 1'(cin_sel), 8'(imm)};
    bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 32'(w < 20), 1);
  endtask
  task automatic do_instr(input int op, input int rd, input int rs1, input int rs2,
                          input int imm_sel, input int cin_sel, input int imm, input int hold,
                          output int od, output int oc);
    int er, ec;
    offer(op, rd, rs1, rs2, imm_sel, cin_sel, imm);
    model_exec(op, rd, rs1, rs2, imm_sel, cin_sel, imm, er, ec);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = hold == 0;
    check("exec_in_ready", 32'(bus.in_ready), 0);
    check("exec_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("resp_out_valid", 32'(bus.out_valid), 1);
    check("resp_out_data", 32'(bus.out_data), 32'(er));
    check("resp_out_carry", 32'(bus.out_carry), 32'(ec));
    check("resp_in_ready", 32'(bus.in_ready), 0);
    od = int'(bus.out_data);
    oc = int'(bus.out_carry);
    if (hold > 0) begin
      bus.in_instr = 19'($urandom);
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", 32'(bus.out_valid), 1);
        check("hold_out_data", 32'(bus.out_data), 32'(er));
        check("hold_out_carry", 32'(bus.out_carry), 32'(ec));
        check("hold_in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_out_valid", 32'(bus.out_valid), 0);
    check("idle_in_ready", 32'(bus.in_ready), 1);
    bus.dbg_addr = 2'(rd);
    #1 check("dbg_rd", 32'(bus.dbg_data), 32'(m_reg[rd]));
  endtask
  task automatic reset_in_exec(input int rd);
    offer(0, rd, 1, 2, 1, 0, 8'h5A);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    model_reset();
    #1 check_reset_state("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(bus.out_valid), 0);
      check("post_rst_in_ready", 32'(bus.in_ready), 1);
    end
    bus.out_ready = 1'b0;
    bus.dbg_addr = 2'(rd);
    #1 check("post_rst_rd", 32'(bus.dbg_data), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int od, oc;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.dbg_addr  = 2'd0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    do_instr(6, 1, 0, 0, 1, 0, 8'h7F, 0, od, oc);
    check("load_7f_data", 32'(od), 32'h7F);
    check("load_7f_carry", 32'(oc), 0);
    do_instr(0, 2, 1, 0, 1, 0, 8'h81, 0, od, oc);
    check("add_81_data", 32'(od), 32'h00);
    check("add_81_carry", 32'(oc), 1);
    do_instr(0, 3, 1, 0, 1, 1, 8'h01, 5, od, oc);
    check("add_cin_data", 32'(od), 32'h81);
    check("add_cin_carry", 32'(oc), 0);
    do_instr(5, 1, 1, 0, 0, 0, 0, 1, od, oc);
    check("not_r1", 32'(od), 32'h80);
    do_instr(1, 0, 1, 1, 0, 0, 0, 0, od, oc);
    check("sub_self", 32'(od), 32'h00);
    for (int k = 0; k < 40; k++)
      do_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, MASK),
               $urandom_range(0, 3), od, oc);
    reset_in_exec(2);
    for (int k = 0; k < 10; k++)
      do_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, MASK),
               $urandom_range(0, 2), od, oc);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/register/result width.
REQ-002 Parameter OPCODE_WIDTH, default 3, width of instruction_code field.
REQ-003 Parameter INSTR_WIDTH, default OPCODE_WIDTH+8+DATA_WIDTH (19), instruction word width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  sequencer accepts instruction this cycle.
REQ-008 in_instr  input  INSTR_WIDTH  {opcode, rd[1:0], rs1[1:0], rs2[1:0], imm_sel, cin_sel, imm[DATA_WIDTH-1:0]}, MSB first.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_data  output  DATA_WIDTH  result written to rd.
REQ-012 out_carry  output  1  carry flag after the instruction.
REQ-013 dbg_addr  input  2  register-file read address.
REQ-014 dbg_data  output  DATA_WIDTH  combinational read of register dbg_addr.

Function
REQ-015 Register file SHALL hold 4 registers r0..r3 of DATA_WIDTH plus one carry flag.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; in_ready=1 only in IDLE.
REQ-017 IDLE: in_valid&&in_ready SHALL latch in_instr and move to EXEC; otherwise stay.
REQ-018 EXEC (exactly one cycle): ALU i_1=r[rs1]; i_2=imm if imm_sel else r[rs2]; carry_in=carry flag if cin_sel else 0; op_code=opcode.
REQ-019 End of EXEC SHALL write ALU o_main into r[rd], carry_out into carry flag, capture out_data/out_carry, move to RESP.
REQ-020 Operand reads SHALL use pre-write values (rd equal to rs1/rs2 legal).
REQ-021 Arithmetic per opcode: ADD {carry,result}=i_1+i_2+cin (DATA_WIDTH+1 bits); SUBTRACT result=(i_1-i_2+cin) mod 2^DATA_WIDTH, carry 0; AND/OR/XOR bitwise, carry 0; NOT ~i_1, carry 0; any other code = LOAD: result=i_2, carry=cin.
REQ-022 RESP: out_valid=1; out_data/out_carry SHALL stay stable until out_valid&&out_ready, then return to IDLE next cycle.
REQ-023 out_ready high on first RESP cycle SHALL complete in that cycle; minimum 3 cycles per instruction, accept-to-out_valid latency 2 cycles.
REQ-024 in_valid in EXEC/RESP SHALL be ignored (not latched); upstream holds it.
REQ-025 dbg_data SHALL reflect register writes from the cycle after the write edge.

Reset
REQ-026 rst SHALL immediately force state IDLE, r0..r3=0, carry flag=0, out_valid=0, out_data=0, out_carry=0, in_ready=1.
REQ-027 rst in EXEC or RESP SHALL drop the pending instruction/result with no register write.

Structure
REQ-028 instruction_code enum (ADD, SUBTRACT, AND_OP, OR_OP, XOR_OP, NOT_OP, LOAD_OP) and FSM state typedef SHALL live in alu_pkg.
REQ-029 Field offsets of in_instr SHALL be package constants.
REQ-030 Sub-module: one instance of alu (DATA_WIDTH, OPCODE_WIDTH passed through); no arithmetic duplicated in alu_sequencer.

Verification
REQ-031 Reset mid-stream -> in_ready=1, out_valid=0, dbg_data=0 for all addresses, out_carry=0.
REQ-032 LOAD_OP rd=1 imm_sel=1 imm=0x7F -> out_data=0x7F, out_carry=0 two cycles after accept; then ADD rd=2 rs1=1 imm=0x81 cin_sel=0 -> out_data=0x00, out_carry=1.
REQ-033 Following ADD rd=3 rs1=1 imm=0x01 cin_sel=1 -> out_data=0x81, out_carry=0; NOT rd=1 rs1=1 -> r1=0x80; SUBTRACT rd=0 rs1=1 rs2=1 cin_sel=0 -> 0x00.
REQ-034 out_ready low 5 cycles in RESP -> out_valid, out_data stable, in_ready=0, offered instruction not taken until after handshake.
REQ-035 rst pulse during EXEC of ADD rd=2 -> r2 stays 0, out_valid never asserted, in_ready=1 after release.
